// File: rtl/ysyx_24070016_mem_pkg.sv
// Shared types for the memory responder: FSM encoding, default base, counter width.
// Used by the responder top, its storage array and its bus interface.
package ysyx_24070016_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef logic [31:0] word_t;

  localparam word_t MEM_BASE = 32'h8000_0000;
  localparam int    CNT_W    = 4;

endpackage

// File: rtl/ysyx_24070016_mem_responder_if.sv
// Request/response bundle between a requester (master) and the memory responder (slave).
// The master drives requests and rsp_ready; the slave drives req_ready and responses.
interface ysyx_24070016_mem_responder_if;
  import ysyx_24070016_mem_pkg::*;

  logic       req_valid;
  logic       req_ready;
  word_t      req_addr;
  logic       req_wen;
  word_t      req_wdata;
  logic [3:0] req_wmask;
  logic       rsp_valid;
  logic       rsp_ready;
  word_t      rsp_rdata;
  logic       rsp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/ysyx_24070016_MemArray.sv
// Single-port word storage: byte-masked synchronous write, read sampled on the same edge.
// Contents are never reset; only the port is clocked.
module ysyx_24070016_MemArray
  import ysyx_24070016_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  word_t         wdata,
  input  logic [3:0]    wmask,
  output word_t         rdata
);

  word_t mem_q [DEPTH];
  word_t rdata_q;

  // Read returns the pre-write contents of the word.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q <= mem_q[idx];
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (wmask[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ysyx_24070016_mem_responder.sv
// Fixed-latency memory responder: IDLE/WAIT/RESP handshake FSM over a word array.
// Define YSYX_24070016_MEM_ERR_EN to flag out-of-range addresses instead of wrapping.
module ysyx_24070016_mem_responder
  import ysyx_24070016_mem_pkg::*;
#(
  parameter int    DEPTH   = 1024,
  parameter int    LATENCY = 2,
  parameter word_t BASE    = MEM_BASE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  word_t      req_addr,
  input  logic       req_wen,
  input  word_t      req_wdata,
  input  logic [3:0] req_wmask,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output word_t      rsp_rdata,
  output logic       rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAT_M1 =
    (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  word_t            addr_q, addr_d;
  word_t            wdata_q, wdata_d;
  logic [3:0]       wmask_q, wmask_d;
  logic             wen_q, wen_d;
  logic             err_q, err_d;

  logic       live;
  word_t      m_addr;
  word_t      off;
  logic       oob;
  logic       m_err;
  logic       mem_en;
  logic       mem_we;
  word_t      arr_rdata;
  logic       unused_bits;

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);

  // With zero latency the array fires on the acceptance edge, so use the live request.
  assign live   = (state_q == ST_IDLE);
  assign m_addr = live ? req_addr : addr_q;
  assign off    = m_addr - BASE;
  assign oob    = |(off >> (AW + 2));

`ifdef YSYX_24070016_MEM_ERR_EN
  assign m_err   = oob;
  assign rsp_err = rsp_valid & err_q;
`else
  assign m_err   = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign unused_bits = ^{off[1:0], oob};

  assign mem_en = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign mem_we = mem_en && (live ? req_wen : wen_q) && !m_err;

  ysyx_24070016_MemArray #(
    .DEPTH(DEPTH)
  ) u_arr (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .idx   (off[AW+1:2]),
    .wdata (live ? req_wdata : wdata_q),
    .wmask (live ? req_wmask : wmask_q),
    .rdata (arr_rdata)
  );

  assign rsp_rdata =
    (rsp_valid && !wen_q && !err_q) ? arr_rdata : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    wen_d   = wen_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          wen_d   = req_wen;
          err_d   = m_err;
          if (LATENCY == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      wen_q   <= wen_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_24070016_mem_responder.sv
// Bench for the memory responder: directed table, hand-written corner sequences,
// and randomized traffic against a word-array reference model.
module tb_ysyx_24070016_mem_responder;
  import ysyx_24070016_mem_pkg::*;

  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_24070016_mem_responder_if bus();

  ysyx_24070016_mem_responder #(
    .DEPTH(DEPTH), .LATENCY(LAT), .BASE(BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (bus.req_valid),
    .req_ready (bus.req_ready),
    .req_addr  (bus.req_addr),
    .req_wen   (bus.req_wen),
    .req_wdata (bus.req_wdata),
    .req_wmask (bus.req_wmask),
    .rsp_valid (bus.rsp_valid),
    .rsp_ready (bus.rsp_ready),
    .rsp_rdata (bus.rsp_rdata),
    .rsp_err   (bus.rsp_err)
  );

  logic        l0_req_valid, l0_req_ready, l0_req_wen;
  logic [31:0] l0_req_addr, l0_req_wdata, l0_rsp_rdata;
  logic [3:0]  l0_req_wmask;
  logic        l0_rsp_valid, l0_rsp_ready, l0_rsp_err;

  ysyx_24070016_mem_responder #(
    .DEPTH(16), .LATENCY(0), .BASE(BASE)
  ) u_l0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (l0_req_valid),
    .req_ready (l0_req_ready),
    .req_addr  (l0_req_addr),
    .req_wen   (l0_req_wen),
    .req_wdata (l0_req_wdata),
    .req_wmask (l0_req_wmask),
    .rsp_valid (l0_rsp_valid),
    .rsp_ready (l0_rsp_ready),
    .rsp_rdata (l0_rsp_rdata),
    .rsp_err   (l0_rsp_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  logic [31:0] mdl [int];

  function automatic int widx(input logic [31:0] a);
    logic [31:0] w;
    w = ((a - BASE) >> 2) % DEPTH;
    return int'(w);
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
  endfunction

  task automatic model_op(input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] m,
                          output logic [31:0] rd, output logic er);
    logic [31:0] cur;
    int i;
    rd = '0;
    er = 1'b0;
`ifdef YSYX_24070016_MEM_ERR_EN
    if (!in_rng(a)) begin
      er = 1'b1;
      return;
    end
`endif
    i   = widx(a);
    cur = mdl.exists(i) ? mdl[i] : 32'hx;
    if (w) begin
      for (int b = 0; b < 4; b++)
        if (m[b]) cur[8*b +: 8] = d[8*b +: 8];
      mdl[i] = cur;
    end else begin
      rd = cur;
    end
  endtask

  task automatic txn(input logic [31:0] a, input logic w,
                     input logic [31:0] d, input logic [3:0] m,
                     input int hold, input string nm,
                     output logic [31:0] rd, output logic er);
    int lat;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_wen   = w;
    bus.req_wdata = d;
    bus.req_wmask = m;
    @(posedge clk); #1;
    bus.req_addr  = $urandom;
    bus.req_wen   = 1'($urandom);
    bus.req_wdata = $urandom;
    bus.req_wmask = 4'($urandom);
    lat = 1;
    while (!bus.rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, lat, LAT + 1);
    chk({nm, " req_ready in RESP"}, bus.req_ready, 1'b0);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, " stall valid"}, bus.rsp_valid, 1'b1);
      chk({nm, " stall rdata"}, bus.rsp_rdata, rd);
      chk({nm, " stall req_ready"}, bus.req_ready, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({nm, " release"}, {bus.rsp_valid, bus.req_ready}, 2'b01);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [31:0] rd, erd;
    logic        er, eer;

    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wen = 1'b0;
    bus.req_wdata = '0;   bus.req_wmask = '0; bus.rsp_ready = 1'b0;
    l0_req_valid = 1'b0; l0_req_addr = '0; l0_req_wen = 1'b0;
    l0_req_wdata = '0;   l0_req_wmask = '0; l0_rsp_ready = 1'b0;

    vt.push_back('{32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0});
    vt.push_back('{32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0});
    vt.push_back('{32'h8000_0020, 1'b1, 32'h1122_3344, 4'hF, 0, 32'h0, 1'b0});
    vt.push_back('{32'h8000_0020, 1'b1, 32'h0000_00AA, 4'h1, 0, 32'h0, 1'b0});
    vt.push_back('{32'h8000_0020, 1'b0, 32'h0, 4'h0, 5, 32'h1122_33AA, 1'b0});
    vt.push_back('{32'h8000_0023, 1'b0, 32'h0, 4'h0, 1, 32'h1122_33AA, 1'b0});
    vt.push_back('{32'h8000_0020, 1'b1, 32'hFFFF_FFFF, 4'hA, 0, 32'h0, 1'b0});
    vt.push_back('{32'h8000_0020, 1'b0, 32'h0, 4'h0, 0, 32'hFF22_FFAA, 1'b0});
`ifdef YSYX_24070016_MEM_ERR_EN
    vt.push_back('{32'h8000_0000, 1'b1, 32'h1234_5678, 4'hF, 0, 32'h0, 1'b0});
    vt.push_back('{32'h8000_1000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b1});
    vt.push_back('{32'h8000_1000, 1'b1, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 1'b1});
    vt.push_back('{32'h8000_0000, 1'b0, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0});
`else
    vt.push_back('{32'h8000_1000, 1'b1, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 1'b0});
    vt.push_back('{32'h8000_0000, 1'b0, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b0});
`endif

    #12;
    chk("reset rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset rsp_err", bus.rsp_err, 1'b0);
    chk("reset req_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post-reset req_ready", bus.req_ready, 1'b1);

    foreach (vt[i]) begin
      txn(vt[i].addr, vt[i].wen, vt[i].wdata, vt[i].wmask, vt[i].hold,
          $sformatf("vec%0d", i), rd, er);
      model_op(vt[i].addr, vt[i].wen, vt[i].wdata, vt[i].wmask, erd, eer);
      chk($sformatf("vec%0d rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d err", i), er, vt[i].exp_er);
    end

    // Reset while a write is waiting: the old word must survive.
    txn(32'h8000_0040, 1'b1, 32'h5555_5555, 4'hF, 0, "rstw pre", rd, er);
    model_op(32'h8000_0040, 1'b1, 32'h5555_5555, 4'hF, erd, eer);
    bus.req_valid = 1'b1; bus.req_addr = 32'h8000_0040;
    bus.req_wen = 1'b1; bus.req_wdata = 32'hAAAA_AAAA; bus.req_wmask = 4'hF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rstw in WAIT valid", bus.rsp_valid, 1'b0);
    chk("rstw in WAIT ready", bus.req_ready, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("rstw rsp_valid", bus.rsp_valid, 1'b0);
    chk("rstw rsp_rdata", bus.rsp_rdata, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rstw req_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    txn(32'h8000_0040, 1'b0, 32'h0, 4'h0, 0, "rstw read", rd, er);
    chk("rstw old data", rd, 32'h5555_5555);

    // Randomized traffic over a pool of words, including wrapped aliases.
    for (int j = 0; j < 8; j++) begin
      logic [31:0] a, d;
      a = BASE + 32'h100 + 32'(4 * j);
      d = $urandom;
      txn(a, 1'b1, d, 4'hF, 0, "pool init", rd, er);
      model_op(a, 1'b1, d, 4'hF, erd, eer);
    end
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a, d;
      logic        w;
      logic [3:0]  m;
      int          k;
      k = $urandom_range(0, 4);
      a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      if (k == 0) a = a - 32'(4 * DEPTH);
      if (k == 4) a = a + 32'(4 * DEPTH);
      w = 1'($urandom);
      d = $urandom;
      m = 4'($urandom);
      txn(a, w, d, m, $urandom_range(0, 2), $sformatf("rnd%0d", n), rd, er);
      model_op(a, w, d, m, erd, eer);
      chk($sformatf("rnd%0d rdata a=%h", n, a), rd, erd);
      chk($sformatf("rnd%0d err", n), er, eer);
    end

    // Zero-latency instance: response right after the accepting edge.
    l0_req_valid = 1'b1; l0_req_addr = BASE + 32'h8;
    l0_req_wen = 1'b1; l0_req_wdata = 32'h0BAD_CAFE; l0_req_wmask = 4'hF;
    chk("l0 ready before", l0_req_ready, 1'b1);
    @(posedge clk); #1;
    l0_req_valid = 1'b0;
    chk("l0 write valid", l0_rsp_valid, 1'b1);
    chk("l0 write rdata", l0_rsp_rdata, 32'h0);
    chk("l0 write req_ready", l0_req_ready, 1'b0);
    l0_rsp_ready = 1'b1;
    @(posedge clk); #1;
    l0_rsp_ready = 1'b0;
    chk("l0 write release", l0_rsp_valid, 1'b0);
    l0_req_valid = 1'b1; l0_req_wen = 1'b0; l0_req_wdata = '0;
    @(posedge clk); #1;
    l0_req_valid = 1'b0;
    chk("l0 read valid", l0_rsp_valid, 1'b1);
    chk("l0 read rdata", l0_rsp_rdata, 32'h0BAD_CAFE);
    l0_rsp_ready = 1'b1;
    @(posedge clk); #1;
    l0_rsp_ready = 1'b0;
    chk("l0 read release", l0_rsp_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
